credit_session_timer: RTL and testbench

- Downstream of the bill-validator controller; consumes its 8-bit running total `billAccumed`, which only ever increases and wraps modulo 256.
- Converts newly inserted money into viewing seconds and counts them down at 1 Hz.
- Drives the binocular view-enable (shutter) and a low-time warning blink.
- Exposes remaining seconds for the display and a credit pulse for the buzzer.

---
 rtl/binoc_pkg.sv | 14 +
 rtl/tick_divider.sv | 31 +++
 rtl/credit_session_timer.sv | 128 ++++++++++++
 tb/tb_credit_session_timer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/binoc_pkg.sv
// Shared types and constants for the binocular viewer control blocks.
package binoc_pkg;

    localparam int CLK_HZ  = 10_000_000;
    localparam int MONEY_W = 8;
    localparam int SEC_W   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WARN = 2'd2
    } session_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider that emits a one-cycle tick every CLK_HZ/RATE_HZ enabled cycles.
module tick_divider #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int RATE_HZ = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int DIV   = (CLK_HZ / RATE_HZ < 1) ? 1 : CLK_HZ / RATE_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == TERM) ? '0 : count + CNT_W'(1);
        end
    end

    assign tick = en && !clear && (count == TERM);

endmodule

// File: rtl/credit_session_timer.sv
// Converts money increments from the bill validator into viewing seconds and runs
// the shutter session (IDLE/RUN/WARN) with a 1 Hz countdown and warning blink.
module credit_session_timer #(
    parameter int CLK_HZ       = binoc_pkg::CLK_HZ,
    parameter int PRICE_UNIT   = 10,
    parameter int SEC_PER_UNIT = 6,
    parameter int MAX_SECONDS  = 3599,
    parameter int WARN_SECONDS = 10,
    parameter int BLINK_HZ     = 2
) (
    input  logic        CLK_10MHZ,
    input  logic        nRESET,
    input  logic [7:0]  billAccumed,
    input  logic        creditEnable,
    output logic        viewEnable,
    output logic [11:0] secondsLeft,
    output logic        warnBlink,
    output logic        sessionActive,
    output logic        creditPulse
);

    import binoc_pkg::*;

    localparam logic [8:0]       PEND_MAX = 9'd511;
    localparam logic [9:0]       PRICE    = 10'(PRICE_UNIT);
    localparam logic [SEC_W:0]   SEC_ADD  = (SEC_W + 1)'(SEC_PER_UNIT);
    localparam logic [SEC_W:0]   SEC_MAX  = (SEC_W + 1)'(MAX_SECONDS);
    localparam logic [SEC_W-1:0] SEC_WARN = SEC_W'(WARN_SECONDS);

    session_state_t     state, state_next;
    logic               first_sample;
    logic [MONEY_W-1:0] prev_total;
    logic [MONEY_W-1:0] delta;
    logic [8:0]         pend_money;
    logic [8:0]         pend_next;
    logic               convert;
    logic               sec_tick;
    logic               blink_tick;
    logic [SEC_W:0]     sec_sum;
    logic [SEC_W-1:0]   sec_next;
    logic               blink_next;

    function automatic logic [8:0] sat_money(input logic [9:0] value);
        return (value > {1'b0, PEND_MAX}) ? PEND_MAX : value[8:0];
    endfunction

    function automatic logic [SEC_W-1:0] sat_seconds(input logic [SEC_W:0] value);
        return (value > SEC_MAX) ? SEC_MAX[SEC_W-1:0] : value[SEC_W-1:0];
    endfunction

    tick_divider #(.CLK_HZ(CLK_HZ), .RATE_HZ(1)) second_div (
        .clk   (CLK_10MHZ),
        .rst_n (nRESET),
        .en    (state != IDLE),
        .clear (state == IDLE),
        .tick  (sec_tick)
    );

    tick_divider #(.CLK_HZ(CLK_HZ), .RATE_HZ(2 * BLINK_HZ)) blink_div (
        .clk   (CLK_10MHZ),
        .rst_n (nRESET),
        .en    (state == WARN),
        .clear (state != WARN),
        .tick  (blink_tick)
    );

    // The first cycle after reset only captures the baseline, so a non-zero total is not credited.
    assign delta   = first_sample ? '0 : billAccumed - prev_total;
    assign convert = creditEnable && ({1'b0, pend_money} >= PRICE);
    assign pend_next = sat_money({1'b0, pend_money} - (convert ? PRICE : 10'd0) + {2'b00, delta});

    always_comb begin
        sec_sum  = {1'b0, secondsLeft} + (convert ? SEC_ADD : '0);
        sec_next = sat_seconds(sec_sum);
        if (sec_tick && (sec_next != '0)) begin
            sec_next = sec_next - SEC_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        blink_next = 1'b0;
        case (state)
            IDLE: if (sec_next != '0) state_next = RUN;
            RUN: begin
                if (sec_next == '0)            state_next = IDLE;
                else if (sec_next <= SEC_WARN) state_next = WARN;
            end
            WARN: begin
                if (sec_next == '0)           state_next = IDLE;
                else if (sec_next > SEC_WARN) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
        if (state_next == WARN) begin
            if (state != WARN)   blink_next = 1'b1;
            else if (blink_tick) blink_next = ~warnBlink;
            else                 blink_next = warnBlink;
        end
    end

    always_ff @(posedge CLK_10MHZ or negedge nRESET) begin
        if (!nRESET) begin
            state         <= IDLE;
            first_sample  <= 1'b1;
            prev_total    <= '0;
            pend_money    <= '0;
            secondsLeft   <= '0;
            creditPulse   <= 1'b0;
            warnBlink     <= 1'b0;
            viewEnable    <= 1'b0;
            sessionActive <= 1'b0;
        end else begin
            state        <= state_next;
            first_sample <= 1'b0;
            if (first_sample || (delta != '0)) begin
                prev_total <= billAccumed;
            end
            pend_money    <= pend_next;
            secondsLeft   <= sec_next;
            creditPulse   <= convert;
            warnBlink     <= blink_next;
            viewEnable    <= (state_next != IDLE);
            sessionActive <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_credit_session_timer.sv
// Directed bench for credit_session_timer with a 100 Hz clock so sessions run in a few thousand cycles.
module tb_credit_session_timer;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  bill;
    logic        cen;
    logic        view;
    logic [11:0] secs;
    logic        blink;
    logic        active;
    logic        pulse;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    credit_session_timer #(
        .CLK_HZ       (100),
        .PRICE_UNIT   (10),
        .SEC_PER_UNIT (6),
        .MAX_SECONDS  (3599),
        .WARN_SECONDS (10),
        .BLINK_HZ     (2)
    ) dut (
        .CLK_10MHZ     (clk),
        .nRESET        (nrst),
        .billAccumed   (bill),
        .creditEnable  (cen),
        .viewEnable    (view),
        .secondsLeft   (secs),
        .warnBlink     (blink),
        .sessionActive (active),
        .creditPulse   (pulse)
    );

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          n;
        int          pulses;
        int          max_sec;
        logic [11:0] pattern;

        nrst = 1'b0;
        bill = 8'd30;
        cen  = 1'b1;
        cycle(2);
        check("reset_view", view, 0);
        check("reset_secs", secs, 0);
        check("reset_blink", blink, 0);
        check("reset_active", active, 0);
        check("reset_pulse", pulse, 0);

        // Baseline capture then a single 10-unit bill.
        nrst = 1'b1;
        cycle(1);
        check("baseline_secs", secs, 0);
        bill = 8'd40;
        cycle(1);
        check("no_initial_credit_secs", secs, 0);
        check("no_initial_credit_pulse", pulse, 0);
        cycle(1);
        check("single_bill_pulse", pulse, 1);
        check("single_bill_secs", secs, 6);
        check("single_bill_view", view, 1);
        cycle(1);
        check("single_bill_one_pulse", pulse, 0);
        check("warn_entry_blink", blink, 1);
        check("warn_entry_active", active, 1);
        cycle(24);
        check("blink_hold_24", blink, 1);
        cycle(1);
        check("blink_toggle_25", blink, 0);
        cycle(25);
        check("blink_toggle_50", blink, 1);
        n = 0;
        while (view && n < 700) begin
            cycle(1);
            n++;
        end
        check("session_end_cycles", n, 549);
        check("session_end_secs", secs, 0);
        check("session_end_blink", blink, 0);
        check("session_end_active", active, 0);

        // 100 units at once: ten consecutive quanta.
        bill = 8'd140;
        pattern = '0;
        for (int i = 0; i < 12; i++) begin
            cycle(1);
            pattern[i] = pulse;
        end
        check("large_bill_pulse_pattern", pattern, 12'h7FE);
        check("large_bill_secs", secs, 60);
        check("large_bill_view", view, 1);

        // Countdown into the warning window.
        n = 0;
        while (!blink && n < 6000) begin
            cycle(1);
            n++;
        end
        check("warn_entry_cycles", n, 4990);
        check("warn_entry_secs", secs, 10);
        cycle(25);
        check("warn_blink_off", blink, 0);
        cycle(25);
        check("warn_blink_on", blink, 1);

        n = 0;
        while (secs != 12'd5 && n < 1000) begin
            cycle(1);
            n++;
        end
        check("reach_5s_cycles", n, 450);
        bill = 8'd150;
        cycle(2);
        check("warn_credit_secs", secs, 11);
        check("warn_credit_blink", blink, 0);
        check("warn_credit_pulse", pulse, 1);
        check("warn_credit_active", active, 1);

        // Credit landing on the same edge as the second tick.
        cycle(96);
        check("pre_coincide_secs", secs, 11);
        bill = 8'd160;
        cycle(2);
        check("coincide_secs", secs, 16);
        check("coincide_pulse", pulse, 1);

        // Wrap of the running total: 250 -> 4 is a 10-unit step.
        bill = 8'd250;
        cycle(10);
        check("pre_wrap_secs", secs, 70);
        bill = 8'd4;
        cycle(2);
        check("wrap_secs", secs, 76);
        check("wrap_pulse", pulse, 1);

        // Pump money until the counter pins at MAX_SECONDS.
        pulses  = 0;
        max_sec = 0;
        for (int i = 0; i < 702; i++) begin
            if (i < 700) bill = bill + 8'd10;
            cycle(1);
            pulses += int'(pulse);
            if (int'(secs) > max_sec) max_sec = int'(secs);
        end
        check("sat_pulse_count", pulses, 700);
        check("sat_max_secs", max_sec, 3599);
        n = 0;
        while (secs != 12'd3596 && n < 500) begin
            cycle(1);
            n++;
        end
        check("sat_reach_3596", secs, 3596);
        bill = bill + 8'd10;
        cycle(2);
        check("sat_clamp_secs", secs, 3599);
        check("sat_clamp_pulse", pulse, 1);

        // Asynchronous reset mid-session.
        nrst = 1'b0;
        #2;
        check("async_reset_view", view, 0);
        check("async_reset_secs", secs, 0);
        check("async_reset_blink", blink, 0);
        check("async_reset_active", active, 0);
        check("async_reset_pulse", pulse, 0);
        cycle(2);
        nrst = 1'b1;
        cycle(3);
        check("no_double_credit_secs", secs, 0);

        // Service mode holds pending money until enable returns.
        cen  = 1'b0;
        bill = bill + 8'd20;
        cycle(4);
        check("service_secs", secs, 0);
        check("service_pulse", pulse, 0);
        check("service_active", active, 0);
        cen = 1'b1;
        cycle(1);
        check("enable_pulse_1", pulse, 1);
        check("enable_secs_1", secs, 6);
        cycle(1);
        check("enable_pulse_2", pulse, 1);
        check("enable_secs_2", secs, 12);
        cycle(1);
        check("enable_pulse_done", pulse, 0);
        check("enable_secs_final", secs, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
